tdm_slot_scheduler: RTL and testbench
=====================================

Name: tdm_slot_scheduler

Overview:
- Time-division scheduler that shares one counter-timed resource slot among NUM_REQ requesters.
- A mod-SLOT_CYCLES slot counter, equivalent to the team's mod-13 counter at default settings, times each grant.
- Round-robin arbitration between slots, with a one-cycle dead gap between grants.
- Sits between requesting datapath blocks and the shared resource. Drives the one-hot grant and exposes slot timing for downstream sequencing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SLOT_CYCLES, 13, maximum grant length in clocks. Also the slot counter modulus (2..16).
- CW, 4, slot counter width. Must satisfy 2^CW >= SLOT_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  scheduler enable. While low, slot timing pauses.
- req  input  NUM_REQ  request vector, level-sensitive; bit i belongs to requester i.
- done  input  1  granted requester ends its slot early.
- grant  output  NUM_REQ  one-hot grant, registered.
- grant_id  output  3  index of the current or last granted requester.
- slot_count  output  CW  cycles elapsed in the current slot.
- slot_tc  output  1  terminal-count flag; high when slot_count==SLOT_CYCLES-1 in GRANT.
- busy  output  1  high in GRANT and GAP.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset values: grant=0, grant_id=NUM_REQ-1 (so the first pick starts at requester 0), slot_count=0, slot_tc=0, busy=0, state=IDLE.
- All outputs are registered.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and |req, arbitrate. Next cycle: state=GRANT, grant=onehot(winner), grant_id=winner, slot_count=0.
  - Otherwise stay in IDLE.
- Round-robin winner: the first set req bit, searching upward from grant_id+1 modulo NUM_REQ.
  - Only requester grant_id requesting: it wins again.
- GRANT with en=1, slot_count increments by 1 each cycle. The slot ends, entering GAP next cycle, on the first of:
  - slot_count==SLOT_CYCLES-1 (natural wrap);
  - done=1;
  - req[grant_id]=0.
- On slot end: grant=0 and slot_count=0 in GAP.
- GRANT with en=0: grant is held, slot_count frozen, end conditions are ignored, slot_tc keeps its value.
- GAP (exactly one cycle, grant=0, busy=1):
  - If en=1 and |req, arbitrate and enter GRANT with the new winner.
  - Otherwise go to IDLE.
  - If en=0 in GAP, go to IDLE.
- Simultaneous done and terminal count: one slot end only, no double event.
- Request from a non-granted requester during GRANT has no effect until GAP.
- Counter never exceeds SLOT_CYCLES-1. Wrap is SLOT_CYCLES-1 -> 0, and only happens on the transition to GAP.
- rst asserted in any state, including mid-slot: all outputs take their reset values on the next edge and arbitration history is cleared.
- grant is always zero or one-hot. grant is nonzero only in GRANT.

Optional Feature:
- Macro: TDM_STATS_EN.
- Defined:
  - Adds output slot_total (8 bits), reset to 0.
  - Increments by 1 on every slot end, whether natural, done or req drop.
  - Saturates at 255.
  - Also adds output tc_total (8 bits, saturating), which counts only natural-wrap endings.
- Not defined: neither port exists and there is no extra logic. Core behaviour is identical in both builds.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then en=1, req=0 for 10 cycles -> grant=0, busy=0, slot_count=0, grant_id=3 throughout.
- Natural slot: en=1, req=4'b0001 held, done=0.
  - Grant 4'b0001 appears 1 cycle after req.
  - slot_count runs 0..12; slot_tc=1 at count 12.
  - Then GAP with grant=0 for 1 cycle, then re-grant of requester 0.
- Round-robin: req=4'b1011 held, done pulsed at slot_count=2 each slot -> grant sequence 0,1,3,0,1, each separated by one zero-grant cycle.
- Pause: mid-slot at slot_count=5, en=0 for 4 cycles -> slot_count stays 5 and grant is held. After en=1 the count resumes at 6 and the slot ends after count 12.
- Simultaneous/early end, both in one run:
  - done=1 on the cycle slot_count=12 -> single GAP cycle; with TDM_STATS_EN, slot_total +1 and tc_total +1.
  - req[grant_id] dropped at count 3 -> GAP next cycle.
- Reset mid-slot: rst=1 at slot_count=7 -> next cycle grant=0, slot_count=0, busy=0. The next arbitration picks requester 0 first.

Source files
------------

// File: rtl/tdm_slot_scheduler.sv
// TDM slot scheduler: round-robin grant of one counter-timed slot.
// Optional `TDM_STATS_EN adds saturating slot_total / tc_total counters.
module tdm_slot_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int SLOT_CYCLES = 13,
  parameter int CW          = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_id,
  output logic [CW-1:0]      slot_count,
  output logic               slot_tc,
  output logic               busy
`ifdef TDM_STATS_EN
  ,
  output logic [7:0]         slot_total,
  output logic [7:0]         tc_total
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);
  localparam logic [CW-1:0]      LAST = CW'(SLOT_CYCLES - 1);

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [2:0]         id_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic               tc_q;
  logic               busy_q;

  logic [2:0]         win;
  logic               found;
  logic [NUM_REQ-1:0] sh;
  int                 idx;
  logic               arb_go;
  logic               at_last;
  logic               slot_end;

  // round-robin pick: first requester above the last granted one
  always_comb begin
    win   = id_q;
    found = 1'b0;
    sh    = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(id_q) + i) % NUM_REQ;
      sh  = req >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  // slot end conditions; grant_q is one-hot of id_q while in GRANT
  always_comb begin
    arb_go   = en && (|req);
    at_last  = (cnt_q == LAST);
    slot_end = at_last || done || !(|(req & grant_q));
    cnt_d    = cnt_q + CW'(1);
  end

  // scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= 3'(NUM_REQ - 1);
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TDM_STATS_EN
      slot_total <= '0;
      tc_total   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE, GAP: begin
          cnt_q <= '0;
          tc_q  <= 1'b0;
          if (arb_go) begin
            state_q <= GRANT;
            grant_q <= ONE << win;
            id_q    <= win;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (en) begin
            if (slot_end) begin
              state_q <= GAP;
              grant_q <= '0;
              cnt_q   <= '0;
              tc_q    <= 1'b0;
`ifdef TDM_STATS_EN
              if (slot_total != 8'hFF)
                slot_total <= slot_total + 8'd1;
              if (at_last && tc_total != 8'hFF)
                tc_total <= tc_total + 8'd1;
`endif
            end else begin
              cnt_q <= cnt_d;
              tc_q  <= (cnt_d == LAST);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign grant_id   = id_q;
  assign slot_count = cnt_q;
  assign slot_tc    = tc_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Directed bench for tdm_slot_scheduler.
// Stats counters are checked when TDM_STATS_EN is defined.
module tb_tdm_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [2:0] grant_id;
  logic [3:0] slot_count;
  logic       slot_tc;
  logic       busy;
`ifdef TDM_STATS_EN
  logic [7:0] slot_total;
  logic [7:0] tc_total;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdm_slot_scheduler #(
    .NUM_REQ(4),
    .SLOT_CYCLES(13),
    .CW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req(req),
    .done(done),
    .grant(grant),
    .grant_id(grant_id),
    .slot_count(slot_count),
    .slot_tc(slot_tc),
    .busy(busy)
`ifdef TDM_STATS_EN
    ,
    .slot_total(slot_total),
    .tc_total(tc_total)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_core(input string tag, input int g, input int id,
                          input int c, input int tc, input int b);
    chk({tag, ".grant"}, int'(grant), g);
    chk({tag, ".id"}, int'(grant_id), id);
    chk({tag, ".cnt"}, int'(slot_count), c);
    chk({tag, ".tc"}, int'(slot_tc), tc);
    chk({tag, ".busy"}, int'(busy), b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int rr_seq [5] = '{0, 1, 3, 0, 1};

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    do_reset();
    chk_core("reset", 0, 3, 0, 0, 0);
`ifdef TDM_STATS_EN
    chk("reset.slot_total", int'(slot_total), 0);
    chk("reset.tc_total", int'(tc_total), 0);
`endif

    // idle with no requests
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_core("idle", 0, 3, 0, 0, 0);
    end

    // natural slot end and re-grant of the sole requester
    req = 4'b0001;
    tick();
    for (int k = 0; k <= 12; k++) begin
      chk_core($sformatf("nat%0d", k), 1, 0, k, (k == 12) ? 1 : 0, 1);
      tick();
    end
    chk_core("nat.gap", 0, 0, 0, 0, 1);
    tick();
    chk_core("nat.regrant", 1, 0, 0, 0, 1);
    req = 4'b0000;
    tick();
    chk_core("nat.drop", 0, 0, 0, 0, 1);
    tick();
    chk_core("nat.idle", 0, 0, 0, 0, 0);

    // round robin over 1011 with done at count 2
    do_reset();
    en  = 1'b1;
    req = 4'b1011;
    tick();
    for (int s = 0; s < 5; s++) begin
      chk_core($sformatf("rr%0d", s), 1 << rr_seq[s], rr_seq[s], 0, 0, 1);
      tick();
      tick();
      chk($sformatf("rr%0d.cnt2", s), int'(slot_count), 2);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk_core($sformatf("rr%0d.gap", s), 0, rr_seq[s], 0, 0, 1);
      tick();
    end

    // pause mid-slot, resume, natural end
    do_reset();
    en  = 1'b1;
    req = 4'b0001;
    tick();
    repeat (5) tick();
    chk_core("pause.pre", 1, 0, 5, 0, 1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_core($sformatf("pause%0d", i), 1, 0, 5, 0, 1);
    end
    en = 1'b1;
    tick();
    chk_core("pause.resume", 1, 0, 6, 0, 1);
    repeat (6) tick();
    chk_core("pause.tc", 1, 0, 12, 1, 1);
    tick();
    chk_core("pause.gap", 0, 0, 0, 0, 1);

    // done coincident with terminal count: single end
    tick();
    chk_core("sim.grant", 1, 0, 0, 0, 1);
    repeat (12) tick();
    chk_core("sim.tc", 1, 0, 12, 1, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_core("sim.gap", 0, 0, 0, 0, 1);
`ifdef TDM_STATS_EN
    chk("sim.slot_total", int'(slot_total), 2);
    chk("sim.tc_total", int'(tc_total), 2);
`endif
    tick();
    chk_core("sim.regrant", 1, 0, 0, 0, 1);

    // requester drops its request at count 3
    repeat (3) tick();
    chk("drop.cnt3", int'(slot_count), 3);
    req = 4'b0000;
    tick();
    chk_core("drop.gap", 0, 0, 0, 0, 1);
`ifdef TDM_STATS_EN
    chk("drop.slot_total", int'(slot_total), 3);
    chk("drop.tc_total", int'(tc_total), 2);
`endif
    tick();
    chk_core("drop.idle", 0, 0, 0, 0, 0);

    // reset in the middle of a slot clears history
    req = 4'b0010;
    tick();
    chk_core("mid.grant", 2, 1, 0, 0, 1);
    repeat (7) tick();
    chk("mid.cnt7", int'(slot_count), 7);
    rst = 1'b1;
    tick();
    chk_core("mid.rst", 0, 3, 0, 0, 0);
`ifdef TDM_STATS_EN
    chk("mid.slot_total", int'(slot_total), 0);
`endif
    rst = 1'b0;
    req = 4'b1011;
    tick();
    chk_core("mid.first", 1, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
